// File: rtl/bus_ctrl_if.sv
// Request/response bundle between the control unit and the bus transfer sequencer.
interface bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic [4:0]  read_en;
  logic [15:0] wr_en;
  logic        done;
  logic        err;
  logic        busy;

  // Control unit side: issues transfer requests, observes bus strobes.
  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, read_en, wr_en, done, err, busy
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, read_en, wr_en, done, err, busy
  );
endinterface

// File: rtl/bus_ctrl.sv
// Transfer sequencer for the shared 24-bit datapath bus. Queues (src,dst)
// pairs, drives the bus source select, inserts settle cycles for memory
// sources and pulses a one-hot destination write strobe, one transfer at a time.
module bus_ctrl #(
  parameter int QDEPTH   = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  bus_ctrl_if.slave  bus
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, WRITE} state_t;

  logic [9:0]    fifo_mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [4:0]    head_src;
  logic [4:0]    head_dst;
  logic          head_legal;

  state_t        state;
  logic [2:0]    wait_cnt;
  logic [4:0]    dst_q;
  logic [4:0]    read_en_q;
  logic [15:0]   wr_en_q;
  logic          done_q;
  logic          err_q;

  // im (15) may be read but never written; 0 and 17..31 are not registers.
  function automatic logic is_legal(input logic [4:0] src, input logic [4:0] dst);
    logic src_ok;
    logic dst_ok;
    src_ok = (src >= 5'd1) && (src <= 5'd16);
    dst_ok = (dst >= 5'd1) && (dst <= 5'd16) && (dst != 5'd15);
    return src_ok && dst_ok;
  endfunction

  function automatic logic [15:0] dst_onehot(input logic [4:0] dst);
    logic [3:0] idx;
    idx = 4'(dst - 5'd1);
    return 16'd1 << idx;
  endfunction

  // Memory sources need extra cycles for the bus to settle.
  function automatic logic [2:0] settle_cycles(input logic [4:0] src);
    return (src >= 5'd15) ? 3'(MEM_WAIT) : 3'd0;
  endfunction

  assign full       = (count == CW'(QDEPTH));
  assign empty      = (count == '0);
  assign push       = bus.req_valid && !full;
  assign head_src   = fifo_mem[rd_ptr][9:5];
  assign head_dst   = fifo_mem[rd_ptr][4:0];
  assign head_legal = is_legal(head_src, head_dst);

  // The head is consumed only where the FSM can start (or reject) a transfer.
  assign pop = !empty && ((state == IDLE) || (state == WRITE));

  // FIFO payload storage; contents are meaningless while count says empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.req_src, bus.req_dst};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at QDEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Destination of the transfer currently owning the bus.
  always_ff @(posedge clk) begin
    if (pop && head_legal) dst_q <= head_dst;
  end

  // Transfer sequencer: IDLE -> DRIVE (settle) -> WRITE, chaining directly
  // from WRITE into the next DRIVE so the bus never idles between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 3'd0;
      read_en_q <= 5'd0;
      wr_en_q   <= 16'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_legal) begin
              read_en_q <= head_src;
              wait_cnt  <= settle_cycles(head_src);
              state     <= DRIVE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else begin
            wr_en_q <= dst_onehot(dst_q);
            done_q  <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          wr_en_q <= 16'd0;
          done_q  <= 1'b0;
          if (pop && head_legal) begin
            read_en_q <= head_src;
            wait_cnt  <= settle_cycles(head_src);
            state     <= DRIVE;
          end else begin
            err_q     <= pop;
            read_en_q <= 5'd0;
            state     <= IDLE;
          end
        end
        default: begin
          read_en_q <= 5'd0;
          wr_en_q   <= 16'd0;
          done_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = !full;
  assign bus.read_en   = read_en_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = !empty || (state != IDLE);

endmodule

// File: tb/tb_bus_ctrl.sv
// Scoreboard bench for bus_ctrl: accepted requests push their expected
// outcome into a queue; a monitor pops and compares on every done/err pulse.
module tb_bus_ctrl;

  localparam int MW = 2;

  typedef struct {
    logic        is_err;
    logic [4:0]  src;
    logic [15:0] wr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   done_cnt;
  int   err_cnt;
  int   zero_between;
  bit   saw_not_ready;
  exp_t exp_q[$];
  int   done_cyc[$];

  bus_ctrl_if bif();

  bus_ctrl #(.QDEPTH(4), .MEM_WAIT(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what the transfer should produce, from the legality rules.
  task automatic model_push(input logic [4:0] s, input logic [4:0] d);
    exp_t e;
    int   si;
    int   di;
    si = int'(s);
    di = int'(d);
    e.src    = s;
    e.is_err = !(si >= 1 && si <= 16 && di >= 1 && di <= 16 && di != 15);
    e.wr     = e.is_err ? 16'h0 : 16'(1 << (di - 1));
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [4:0] s, input logic [4:0] d);
    bit acc;
    bit ok;
    ok = 1'b0;
    bif.req_valid = 1'b1;
    bif.req_src   = s;
    bif.req_dst   = d;
    for (int i = 0; i < 60; i++) begin
      acc = bif.req_ready;
      @(posedge clk);
      if (acc) begin
        model_push(s, d);
        ok = 1'b1;
      end
      @(negedge clk);
      if (ok) break;
    end
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bif.busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'(exp_q.size()) + 32'(bif.busy), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("wr_en_onehot", 32'($countones(bif.wr_en) <= 1), 32'd1);
      chk("wr_en_im_bit", 32'(bif.wr_en[14]), 32'd0);
      chk("wr_en_vs_done", 32'(bif.wr_en != 16'h0), 32'(bif.done));
      if (!bif.req_ready) saw_not_ready = 1'b1;
      if (bif.read_en == 5'd0 && bif.busy && done_cyc.size() > 0) zero_between++;
      if (bif.done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      if (bif.err) err_cnt++;
      if (bif.done || bif.err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", {30'd0, bif.done, bif.err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) begin
            chk("resp_kind_err", {30'd0, bif.done, bif.err}, 32'd1);
          end else begin
            chk("resp_kind_done", {30'd0, bif.done, bif.err}, 32'd2);
            chk("read_en_at_write", 32'(bif.read_en), 32'(e.src));
            chk("wr_en_at_write", 32'(bif.wr_en), 32'(e.wr));
          end
        end
      end
    end
  end

  initial begin
    int e0;
    int d0;
    logic [4:0] s;
    logic [4:0] d;
    vectors = 0; miscompares = 0; cyc = 0;
    done_cnt = 0; err_cnt = 0; zero_between = 0; saw_not_ready = 1'b0;
    rst_n = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_src   = 5'd0;
    bif.req_dst   = 5'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_read_en", 32'(bif.read_en), 32'd0);
    chk("rst_wr_en", 32'(bif.wr_en), 32'd0);
    chk("rst_done_err", {30'd0, bif.done, bif.err}, 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_req_ready", 32'(bif.req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single non-memory transfer: ac -> x
    push(5'd14, 5'd5);
    bif.req_valid = 1'b0;
    chk("t1_read_en_c0", 32'(bif.read_en), 32'd0);
    @(negedge clk);
    chk("t1_read_en_c1", 32'(bif.read_en), 32'd14);
    chk("t1_wr_en_c1", 32'(bif.wr_en), 32'd0);
    @(negedge clk);
    chk("t1_read_en_c2", 32'(bif.read_en), 32'd14);
    chk("t1_wr_en_c2", 32'(bif.wr_en), 32'h0010);
    chk("t1_done_c2", 32'(bif.done), 32'd1);
    @(negedge clk);
    chk("t1_read_en_c3", 32'(bif.read_en), 32'd0);
    chk("t1_busy_c3", 32'(bif.busy), 32'd0);
    wait_idle();

    // Memory source: dm -> ar, MW settle cycles
    push(5'd16, 5'd11);
    bif.req_valid = 1'b0;
    chk("t2_read_en_c0", 32'(bif.read_en), 32'd0);
    for (int i = 1; i <= 2 + MW; i++) begin
      @(negedge clk);
      chk("t2_read_en_hold", 32'(bif.read_en), 32'd16);
      chk("t2_wr_en", 32'(bif.wr_en), (i == 2 + MW) ? 32'h0400 : 32'h0);
    end
    @(negedge clk);
    chk("t2_read_en_end", 32'(bif.read_en), 32'd0);
    wait_idle();

    // Back-to-back with a full FIFO (an im read in front lets the queue fill)
    done_cyc.delete();
    zero_between = 0;
    saw_not_ready = 1'b0;
    push(5'd15, 5'd1);
    push(5'd3, 5'd1);
    push(5'd5, 5'd6);
    push(5'd7, 5'd8);
    push(5'd9, 5'd2);
    push(5'd12, 5'd13);
    bif.req_valid = 1'b0;
    wait_idle();
    chk("t3_num_done", 32'(done_cyc.size()), 32'd6);
    if (done_cyc.size() == 6) begin
      for (int i = 1; i < 6; i++)
        chk("t3_done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd2);
    end
    chk("t3_saw_full", 32'(saw_not_ready), 32'd1);
    chk("t3_bus_gaps", 32'(zero_between), 32'd0);

    // Illegal codes
    e0 = err_cnt;
    d0 = done_cnt;
    push(5'd0, 5'd5);
    push(5'd4, 5'd15);
    push(5'd4, 5'd20);
    push(5'd2, 5'd3);
    bif.req_valid = 1'b0;
    wait_idle();
    chk("t4_err_pulses", 32'(err_cnt - e0), 32'd3);
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Reset while (13,11) is in WRITE, with two more queued
    push(5'd13, 5'd11);
    push(5'd1, 5'd2);
    push(5'd3, 5'd4);
    bif.req_valid = 1'b0;
    #1;
    chk("t5_in_write", 32'(bif.wr_en), 32'h0400);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_rst_wr_en", 32'(bif.wr_en), 32'd0);
    chk("t5_rst_read_en", 32'(bif.read_en), 32'd0);
    chk("t5_rst_done", 32'(bif.done), 32'd0);
    #1;
    rst_n = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    chk("t5_busy_after", 32'(bif.busy), 32'd0);
    chk("t5_ready_after", 32'(bif.req_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("t5_queue_lost", 32'(done_cnt - d0), 32'd0);

    // Wrap-around: sequential single transfers, random legal codes
    for (int k = 0; k < 10; k++) begin
      s = 5'($urandom_range(1, 16));
      d = 5'($urandom_range(1, 15));
      if (d == 5'd15) d = 5'd16;
      push(s, d);
      bif.req_valid = 1'b0;
      wait_idle();
    end

    // Random mix including illegal codes and gaps in req_valid
    for (int k = 0; k < 40; k++) begin
      s = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      d = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      push(s, d);
      if ($urandom_range(0, 3) == 0) begin
        bif.req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    bif.req_valid = 1'b0;
    wait_idle();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish before %0d cycles", cyc);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
